// File: rtl/unidade_entrada.sv
// External-input unit: stalls the core until a debounced button press captures the switches.
// Define ENTRADA_SINAL_EN to sign-extend the switch value instead of zero-extending it.
module unidade_entrada #(
    parameter int SW_W       = 10,
    parameter int DEB_CYCLES = 500000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pedido,
    input  logic [SW_W-1:0] chaves,
    input  logic            botao,
    output logic [31:0]     dado_entrada,
    output logic            pausa,
    output logic            pronto
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {
        OCIOSO,
        ESPERA_SOLTAR,
        ESPERA_PRESS,
        DEBOUNCE,
        PRONTO
    } estado_t;

    estado_t         state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [31:0]     dado_n;
    logic [31:0]     ext;
    logic            btn_m, btn_s;
    logic [SW_W-1:0] sw_m, sw_s;
    logic            captura;

    // Two-flop synchronizers for the asynchronous board inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            sw_m  <= '0;
            sw_s  <= '0;
        end else begin
            btn_m <= botao;
            btn_s <= btn_m;
            sw_m  <= chaves;
            sw_s  <= sw_m;
        end
    end

    always_comb begin
        ext = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (i < SW_W) begin
                ext[i] = sw_s[i];
            end else begin
`ifdef ENTRADA_SINAL_EN
                ext[i] = sw_s[SW_W-1];
`else
                ext[i] = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= OCIOSO;
            cnt          <= '0;
            dado_entrada <= 32'd0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            dado_entrada <= dado_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dado_n  = dado_entrada;
        captura = 1'b0;
        pausa   = 1'b0;
        pronto  = 1'b0;
        unique case (state)
            OCIOSO: begin
                pausa = pedido;
                if (pedido) begin
                    state_n = ESPERA_SOLTAR;
                end
            end
            ESPERA_SOLTAR: begin
                pausa = 1'b1;
                if (!btn_s) begin
                    state_n = ESPERA_PRESS;
                end
            end
            ESPERA_PRESS: begin
                pausa = 1'b1;
                if (btn_s) begin
                    state_n = DEBOUNCE;
                    cnt_n   = '0;
                end
            end
            DEBOUNCE: begin
                pausa = 1'b1;
                if (!btn_s) begin
                    state_n = ESPERA_PRESS;
                    cnt_n   = '0;
                end else if (cnt == CNT_MAX) begin
                    captura = 1'b1;
                    state_n = PRONTO;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PRONTO: begin
                pronto  = 1'b1;
                state_n = OCIOSO;
            end
            default: begin
                state_n = OCIOSO;
            end
        endcase
        if (captura) begin
            dado_n = ext;
        end
    end

endmodule
